// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the fetch PC, issues one word request at a time over a req/gnt/rvalid
// handshake, and buffers returned words with their PCs in a small FIFO
// toward decode. A redirect flushes the FIFO, drops any in-flight response
// and restarts fetch at the resolved target.
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets and stall fetch until an aligned redirect arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  output logic        o_misalign,
  output logic [31:0] o_misalign_pc
);

  localparam int unsigned   AW      = $clog2(BUF_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_instr_d [BUF_DEPTH];
  logic [31:0]   buf_pc_q    [BUF_DEPTH];
  logic [31:0]   buf_pc_d    [BUF_DEPTH];

  logic          stall;
  logic [CW-1:0] occupancy;
  logic          grant;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic          misalign_q, misalign_d;
  logic [31:0]   misalign_pc_q, misalign_pc_d;
  logic          redirect_misaligned;

  assign redirect_misaligned = |i_redirect_pc[1:0];
  assign stall               = misalign_q;
  assign o_misalign          = misalign_q;
  assign o_misalign_pc       = misalign_pc_q;
`else
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^i_redirect_pc[1:0];
  assign stall         = 1'b0;
  assign o_misalign    = 1'b0;
  assign o_misalign_pc = '0;
`endif

  assign redirect_tgt  = {i_redirect_pc[31:2], 2'b00};
  // Buffered words plus the one in flight must leave room; a same-cycle pop is not credited.
  assign occupancy     = count_q + CW'(state_q != IDLE);
  assign o_imem_req    = i_rst_n && !i_redirect && !stall && (state_q != DROP)
                         && (occupancy < DEPTH_C);
  assign o_imem_addr   = fetch_pc_q;
  assign grant         = o_imem_req && i_imem_gnt;
  assign push          = (state_q == WAIT) && i_imem_rvalid && !i_redirect;
  assign o_instr_valid = (count_q != '0) && !i_redirect;
  assign pop           = o_instr_valid && i_instr_ready;
  assign o_instr       = buf_instr_q[rd_ptr_q];
  assign o_instr_pc    = buf_pc_q[rd_ptr_q];

  // Next-state: redirect overrides everything, otherwise handshake and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_d    = misalign_q;
    misalign_pc_d = misalign_pc_q;
`endif
    if (i_redirect) begin
      // A response arriving with the redirect is dropped here; otherwise it is dropped later in DROP.
      unique case (state_q)
        WAIT:    state_d = i_imem_rvalid ? IDLE : DROP;
        DROP:    state_d = i_imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
      fetch_pc_d = redirect_tgt;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d = redirect_misaligned;
      if (redirect_misaligned) begin
        misalign_pc_d = i_redirect_pc;
      end
`endif
    end else begin
      unique case (state_q)
        IDLE: if (grant) state_d = WAIT;
        WAIT: if (i_imem_rvalid) state_d = grant ? WAIT : IDLE;
        DROP: if (i_imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (grant) begin
        resp_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        buf_instr_d[wr_ptr_q] = i_imem_rdata;
        buf_pc_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State, PC and FIFO registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
      misalign_pc_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
      misalign_pc_q <= misalign_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios driving a simple instruction
// memory (one outstanding request, configurable response latency) and a
// queue-based model of the fetch front end checked every cycle.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready = 1'b0;
  logic        o_misalign;
  logic [31:0] o_misalign_pc;

  always #5 i_clk = ~i_clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .BUF_DEPTH(2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready),
    .o_misalign    (o_misalign),
    .o_misalign_pc (o_misalign_pc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Stimulus controls
  bit          rst_drive = 1'b0;
  bit          gnt_en = 1'b0;
  bit          ready = 1'b0;
  bit          redir = 1'b0;
  logic [31:0] redir_pc = '0;
  int          lat = 1;

  // Model of the front end
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = 32'h100;
  logic [31:0] m_resp = '0;
  bit          m_out = 1'b0;
  bit          m_disc = 1'b0;
  bit          m_mis = 1'b0;
  bit          m_stall = 1'b0;
  logic [31:0] m_mis_pc = '0;

  // Memory: pending response addresses and due cycles
  logic [31:0] pa[$];
  int          pd[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F69;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    bit          rv, ereq, evalid, grant, pop;
    logic [31:0] rdata;
    ent_t        e;
    @(negedge i_clk);
    i_rst_n       = rst_drive;
    rv            = (pd.size() > 0) && (pd[0] <= cyc);
    rdata         = rv ? mem_word(pa[0]) : 32'hDEAD_BEEF;
    i_imem_rvalid = rv;
    i_imem_rdata  = rdata;
    i_imem_gnt    = gnt_en && ((pd.size() == 0) || rv);
    i_redirect    = redir;
    i_redirect_pc = redir_pc;
    i_instr_ready = ready;
    #1;
    if (rst_drive) begin
      ereq   = !redir && !m_stall && !(m_out && m_disc) && ((q.size() + int'(m_out)) < 2);
      evalid = (q.size() != 0) && !redir;
      chk("imem_req", 32'(o_imem_req), 32'(ereq));
      if (ereq) chk("imem_addr", o_imem_addr, m_pc);
      chk("instr_valid", 32'(o_instr_valid), 32'(evalid));
      if (evalid) begin
        chk("instr", o_instr, q[0].instr);
        chk("instr_pc", o_instr_pc, q[0].pc);
      end
      chk("misalign", 32'(o_misalign), 32'(m_mis));
      chk("misalign_pc", o_misalign_pc, m_mis_pc);
      grant = ereq && i_imem_gnt;
      pop   = evalid && ready;
      if (redir) begin
        q.delete();
        if (m_out) begin
          if (rv) begin
            m_out  = 1'b0;
            m_disc = 1'b0;
          end else begin
            m_disc = 1'b1;
          end
        end
        m_pc = redir_pc & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redir_pc[1:0] != 2'b00) begin
          m_mis    = 1'b1;
          m_stall  = 1'b1;
          m_mis_pc = redir_pc;
        end else begin
          m_mis   = 1'b0;
          m_stall = 1'b0;
        end
`endif
      end else begin
        if (pop) void'(q.pop_front());
        if (rv && m_out) begin
          if (!m_disc) begin
            e.instr = rdata;
            e.pc    = m_resp;
            q.push_back(e);
          end
          m_out  = 1'b0;
          m_disc = 1'b0;
        end
        if (grant) begin
          m_out  = 1'b1;
          m_disc = 1'b0;
          m_resp = m_pc;
          m_pc   = m_pc + 32'd4;
        end
      end
    end
    if (rv) begin
      void'(pa.pop_front());
      void'(pd.pop_front());
    end
    if (i_rst_n && o_imem_req && i_imem_gnt) begin
      pa.push_back(o_imem_addr);
      pd.push_back(cyc + lat);
    end
    redir = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst_drive = 1'b0;
    redir     = 1'b0;
    cycle();
    cycle();
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_instr_pc", o_instr_pc, 32'h0);
    chk("rst_misalign", 32'(o_misalign), 32'd0);
    chk("rst_misalign_pc", o_misalign_pc, 32'h0);
    q.delete();
    m_pc      = 32'h100;
    m_resp    = '0;
    m_out     = 1'b0;
    m_disc    = 1'b0;
    m_mis     = 1'b0;
    m_stall   = 1'b0;
    m_mis_pc  = '0;
    rst_drive = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redir    = 1'b1;
    redir_pc = pc;
    cycle();
  endtask

  initial begin
    bit ready_pat [24] = '{1,1,0,1,0,0,1,1,1,0,1,1,0,1,1,1,0,0,1,1,1,1,0,1};

    gnt_en = 1'b1;
    lat    = 1;
    ready  = 1'b1;
    do_reset();

    // Sequential fetch from RESET_PC with single-cycle memory
    cycle(); chk("t1_addr0", o_imem_addr, 32'h100);
    cycle(); chk("t1_addr1", o_imem_addr, 32'h104);
    cycle(); chk("t1_req_credit", 32'(o_imem_req), 32'd0); chk("t1_pc0", o_instr_pc, 32'h100);
    cycle(); chk("t1_addr2", o_imem_addr, 32'h108); chk("t1_pc1", o_instr_pc, 32'h104);
    repeat (4) cycle();

    // Decode back-pressure fills the FIFO, then fetch resumes
    ready = 1'b0;
    repeat (6) cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_full_valid", 32'(o_instr_valid), 32'd1);
      chk("t2_full_req", 32'(o_imem_req), 32'd0);
    end
    ready = 1'b1;
    repeat (6) cycle();

    // Redirect while a granted request awaits its response
    gnt_en = 1'b0; repeat (4) cycle();
    gnt_en = 1'b1; lat = 3;
    redirect_to(32'h200);
    cycle(); chk("t3_addr200", o_imem_addr, 32'h200);
    redirect_to(32'h400);
    cycle(); chk("t3_drop_req", 32'(o_imem_req), 32'd0);
    lat = 1;
    cycle(); chk("t3_drop_req2", 32'(o_imem_req), 32'd0); chk("t3_drop_valid", 32'(o_instr_valid), 32'd0);
    cycle(); chk("t3_new_req", 32'(o_imem_req), 32'd1); chk("t3_addr400", o_imem_addr, 32'h400);
    chk("t3_no_stale", 32'(o_instr_valid), 32'd0);
    repeat (4) cycle();

    // Redirect coincident with the response
    gnt_en = 1'b0; repeat (4) cycle();
    gnt_en = 1'b1;
    redirect_to(32'h300);
    cycle(); chk("t4_addr300", o_imem_addr, 32'h300);
    redirect_to(32'h600);
    cycle(); chk("t4_req", 32'(o_imem_req), 32'd1); chk("t4_addr600", o_imem_addr, 32'h600);
    chk("t4_empty", 32'(o_instr_valid), 32'd0);
    repeat (3) cycle();

    // Grant held low: address stable, then withdrawn by redirect
    gnt_en = 1'b0; repeat (4) cycle();
    redirect_to(32'h700);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_hold_req", 32'(o_imem_req), 32'd1);
      chk("t5_hold_addr", o_imem_addr, 32'h700);
    end
    redirect_to(32'h800);
    chk("t5_withdraw", 32'(o_imem_req), 32'd0);
    gnt_en = 1'b1;
    cycle(); chk("t5_req", 32'(o_imem_req), 32'd1); chk("t5_addr800", o_imem_addr, 32'h800);
    repeat (3) cycle();

    // Misaligned redirect target
    gnt_en = 1'b0; repeat (4) cycle();
    redirect_to(32'h402);
    cycle();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_mis", 32'(o_misalign), 32'd1);
    chk("t6_mis_pc", o_misalign_pc, 32'h402);
    chk("t6_stall", 32'(o_imem_req), 32'd0);
    gnt_en = 1'b1; repeat (2) cycle();
    chk("t6_stall2", 32'(o_imem_req), 32'd0);
`else
    chk("t6_req", 32'(o_imem_req), 32'd1);
    chk("t6_addr400", o_imem_addr, 32'h400);
    chk("t6_nomis", 32'(o_misalign), 32'd0);
    gnt_en = 1'b1; repeat (2) cycle();
`endif
    gnt_en = 1'b0; repeat (3) cycle();
    redirect_to(32'h500);
    gnt_en = 1'b1;
    cycle(); chk("t6_req500", 32'(o_imem_req), 32'd1); chk("t6_addr500", o_imem_addr, 32'h500);
    chk("t6_mis_clr", 32'(o_misalign), 32'd0);
    repeat (3) cycle();

    // Reset while a response is outstanding; the late response is ignored
    gnt_en = 1'b0; repeat (3) cycle();
    lat = 5; gnt_en = 1'b1;
    cycle();
    do_reset();
    cycle(); chk("t7_addr100", o_imem_addr, 32'h100);
    cycle();
    cycle();
    lat = 1;
    cycle(); chk("t7_stale", 32'(o_instr_valid), 32'd0);
    repeat (6) cycle();

    // Mixed back-pressure with a redirect in the middle
    for (int i = 0; i < 24; i++) begin
      ready = ready_pat[i];
      if (i == 10) begin
        redir    = 1'b1;
        redir_pc = 32'h900;
      end
      cycle();
    end
    ready = 1'b1;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
